// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, write-size encodings and the default read wait.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic [1:0] WSRC_WORD    = 2'b00;
    localparam logic [1:0] WSRC_BYTE    = 2'b01;
    localparam logic [1:0] WSRC_HALF    = 2'b10;
    localparam logic [1:0] WSRC_ILLEGAL = 2'b11;

    localparam int READ_WAIT_DEFAULT = 3;
    localparam int WAIT_CNT_W        = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The arbiter uses the slave modport; the surrounding system uses master.
interface mem_port_arbiter_if;

    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [1:0]  p0_wsrc;
    logic        p0_ack;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [1:0]  p1_wsrc;
    logic        p1_ack;
    logic [31:0] p1_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_write_data_src;
    logic [31:0] mem_read_data;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_wsrc,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_wsrc,
        input  p1_ack, p1_rdata,
        input  mem_read, mem_write, mem_addr, mem_write_data, mem_write_data_src,
        output mem_read_data
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_wsrc,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_wsrc,
        output p1_ack, p1_rdata,
        output mem_read, mem_write, mem_addr, mem_write_data, mem_write_data_src,
        input  mem_read_data
    );

endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Two-way grant decision for mem_port_arbiter: round-robin by default,
// fixed priority (port 0 wins) when ARB_FIXED_PRIO_EN is defined.
module mem_arb_rr (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);

`ifdef ARB_FIXED_PRIO_EN

    logic unused_ok;

    assign grant     = ~req[0];
    assign unused_ok = ^{clk, reset, advance, req[1]};

`else

    logic last_q;

    // On a tie the port that was not served last wins; otherwise the lone requester.
    always_comb begin
        grant = req[1];
        if (req == 2'b11) begin
            grant = ~last_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant;
        end
    end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: serialises port 0/1 requests onto one memory port.
// Grant policy is round-robin unless ARB_FIXED_PRIO_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int READ_WAIT = READ_WAIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(READ_WAIT - 1);

    arb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  port_q, port_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [1:0]            mem_wsrc_q, mem_wsrc_d;
    logic [1:0]            ack_q, ack_d;
    logic [31:0]           rdata0_q, rdata0_d;
    logic [31:0]           rdata1_q, rdata1_d;

    logic [1:0]            req;
    logic                  grant;
    logic                  advance;
    logic                  sel_we;
    logic [31:0]           sel_addr;
    logic [31:0]           sel_wdata;
    logic [1:0]            sel_wsrc;

    assign req     = {bus.p1_req, bus.p0_req};
    assign advance = (state_q == IDLE) && (|req);

    mem_arb_rr u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    assign sel_we    = grant ? bus.p1_we    : bus.p0_we;
    assign sel_addr  = grant ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = grant ? bus.p1_wdata : bus.p0_wdata;
    assign sel_wsrc  = grant ? bus.p1_wsrc  : bus.p0_wsrc;

    // Memory strobes and acks default low; only READ keeps mem_read asserted.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wsrc_d  = mem_wsrc_q;
        ack_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    port_d     = grant;
                    mem_addr_d = sel_addr;
                    cnt_d      = '0;
                    if (sel_we) begin
                        state_d     = WRITE;
                        mem_wdata_d = sel_wdata;
                        mem_wsrc_d  = sel_wsrc;
                        mem_write_d = (sel_wsrc != WSRC_ILLEGAL);
                    end else begin
                        state_d    = READ;
                        mem_read_d = 1'b1;
                    end
                end
            end
            READ: begin
                mem_read_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    mem_read_d    = 1'b0;
                    state_d       = DONE;
                    ack_d[port_q] = 1'b1;
                    if (port_q) begin
                        rdata1_d = bus.mem_read_data;
                    end else begin
                        rdata0_d = bus.mem_read_data;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                state_d       = DONE;
                ack_d[port_q] = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            port_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wsrc_q  <= WSRC_WORD;
            ack_q       <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wsrc_q  <= mem_wsrc_d;
            ack_q       <= ack_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign bus.mem_read           = mem_read_q;
    assign bus.mem_write          = mem_write_q;
    assign bus.mem_addr           = mem_addr_q;
    assign bus.mem_write_data     = mem_wdata_q;
    assign bus.mem_write_data_src = mem_wsrc_q;
    assign bus.p0_ack             = ack_q[0];
    assign bus.p1_ack             = ack_q[1];
    assign bus.p0_rdata           = rdata0_q;
    assign bus.p1_rdata           = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a word-addressed memory model
// and a transaction-level reference for grant order, latency and data.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int RW = READ_WAIT_DEFAULT;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  reqV;
    logic [1:0]  weV;
    logic [31:0] addrV  [2];
    logic [31:0] wdataV [2];
    logic [1:0]  wsrcV  [2];

    logic [31:0] devMem [64];
    logic [31:0] refMem [64];
    logic        memInit;
    logic        preWe;
    logic [5:0]  preIdx;
    logic [31:0] preVal;

    int checkCount = 0;
    int passCount  = 0;

    int          obsAckCyc, obsAckCnt, obsOtherAck, obsRdHigh, obsRdFirst, obsRdLast, obsWrHigh;
    logic [1:0]  obsWrSrc;
    logic [31:0] obsRdata, obsWrData;
    bit          obsAddrOk;
    int          opIdx [2];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.READ_WAIT(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.p0_req        = reqV[0];
    assign bus.p0_we         = weV[0];
    assign bus.p0_addr       = addrV[0];
    assign bus.p0_wdata      = wdataV[0];
    assign bus.p0_wsrc       = wsrcV[0];
    assign bus.p1_req        = reqV[1];
    assign bus.p1_we         = weV[1];
    assign bus.p1_addr       = addrV[1];
    assign bus.p1_wdata      = wdataV[1];
    assign bus.p1_wsrc       = wsrcV[1];
    assign bus.mem_read_data = devMem[bus.mem_addr[7:2]];

    function automatic logic [31:0] applyWrite(input logic [31:0] old, input logic [31:0] a,
                                               input logic [31:0] d, input logic [1:0] src);
        logic [31:0] mask;
        int sh;
        case (src)
            2'b00: return d;
            2'b01: begin
                sh   = 8 * int'(a[1:0]);
                mask = 32'hFF << sh;
                return (old & ~mask) | ((d & 32'hFF) << sh);
            end
            2'b10: begin
                sh   = a[1] ? 16 : 0;
                mask = 32'hFFFF << sh;
                return (old & ~mask) | ((d & 32'hFFFF) << sh);
            end
            default: return old;
        endcase
    endfunction

    function automatic logic [31:0] initWord(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Memory device behind the arbiter; also handles bench preloads.
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 64; i++) devMem[i] <= initWord(i);
        end else if (bus.mem_write) begin
            devMem[bus.mem_addr[7:2]] <= applyWrite(devMem[bus.mem_addr[7:2]], bus.mem_addr,
                                                    bus.mem_write_data, bus.mem_write_data_src);
        end else if (preWe) begin
            devMem[preIdx] <= preVal;
        end
    end

    function automatic logic ackOf(input int p);
        return (p == 1) ? bus.p1_ack : bus.p0_ack;
    endfunction

    function automatic logic [31:0] rdataOf(input int p);
        return (p == 1) ? bus.p1_rdata : bus.p0_rdata;
    endfunction

    task automatic initMem();
        @(negedge clk);
        memInit = 1'b1;
        for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
        @(negedge clk);
        memInit = 1'b0;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        preWe  = 1'b1;
        preIdx = 6'(idx);
        preVal = val;
        refMem[idx] = val;
        @(negedge clk);
        preWe = 1'b0;
    endtask

    // Issues one request and records what the bus does for a fixed window.
    task automatic driveTxn(input int port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] wsrc, input int dropAt);
        @(negedge clk);
        weV[port]    = we;
        addrV[port]  = addr;
        wdataV[port] = wdata;
        wsrcV[port]  = wsrc;
        reqV[port]   = 1'b1;
        obsAckCyc = -1; obsAckCnt = 0; obsOtherAck = 0; obsRdHigh = 0;
        obsRdFirst = -1; obsRdLast = -1; obsWrHigh = 0; obsWrSrc = 2'b00;
        obsRdata = '0; obsWrData = '0; obsAddrOk = 1'b1;
        for (int c = 1; c <= RW + 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_read === 1'b1) begin
                obsRdHigh++;
                if (obsRdFirst < 0) obsRdFirst = c;
                obsRdLast = c;
                if (bus.mem_addr !== addr) obsAddrOk = 1'b0;
            end
            if (bus.mem_write === 1'b1) begin
                obsWrHigh++;
                obsWrSrc  = bus.mem_write_data_src;
                obsWrData = bus.mem_write_data;
                if (bus.mem_addr !== addr) obsAddrOk = 1'b0;
            end
            if (ackOf(port) === 1'b1) begin
                obsAckCnt++;
                if (obsAckCyc < 0) begin
                    obsAckCyc = c;
                    obsRdata  = rdataOf(port);
                end
                reqV[port] = 1'b0;
            end
            if (ackOf(1 - port) === 1'b1) obsOtherAck++;
            if (c == dropAt) reqV[port] = 1'b0;
        end
        reqV[port] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkCount++; if (bus.mem_read !== 1'b0) $display("[TB] FAIL reset_mem_read: got %b expected 0", bus.mem_read); else passCount++;
        checkCount++; if (bus.mem_write !== 1'b0) $display("[TB] FAIL reset_mem_write: got %b expected 0", bus.mem_write); else passCount++;
        checkCount++; if (bus.mem_addr !== 32'h0) $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else passCount++;
        checkCount++; if (bus.mem_write_data !== 32'h0) $display("[TB] FAIL reset_mem_wdata: got %h expected 0", bus.mem_write_data); else passCount++;
        checkCount++; if (bus.mem_write_data_src !== 2'b00) $display("[TB] FAIL reset_mem_wsrc: got %b expected 00", bus.mem_write_data_src); else passCount++;
        checkCount++; if (bus.p0_ack !== 1'b0) $display("[TB] FAIL reset_p0_ack: got %b expected 0", bus.p0_ack); else passCount++;
        checkCount++; if (bus.p1_ack !== 1'b0) $display("[TB] FAIL reset_p1_ack: got %b expected 0", bus.p1_ack); else passCount++;
        checkCount++; if (bus.p0_rdata !== 32'h0) $display("[TB] FAIL reset_p0_rdata: got %h expected 0", bus.p0_rdata); else passCount++;
        checkCount++; if (bus.p1_rdata !== 32'h0) $display("[TB] FAIL reset_p1_rdata: got %h expected 0", bus.p1_rdata); else passCount++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_read_basic();
        preload(4, 32'hDEADBEEF);
        driveTxn(0, 1'b0, 32'h0000_0010, 32'h0, 2'b00, -1);
        checkCount++; if (obsAckCyc != RW + 1) $display("[TB] FAIL read_ack_cycle: got %0d expected %0d", obsAckCyc, RW + 1); else passCount++;
        checkCount++; if (obsAckCnt != 1) $display("[TB] FAIL read_ack_count: got %0d expected 1", obsAckCnt); else passCount++;
        checkCount++; if (obsOtherAck != 0) $display("[TB] FAIL read_other_ack: got %0d expected 0", obsOtherAck); else passCount++;
        checkCount++; if (obsRdHigh != RW) $display("[TB] FAIL read_high_cycles: got %0d expected %0d", obsRdHigh, RW); else passCount++;
        checkCount++; if (obsRdFirst != 1 || obsRdLast != RW) $display("[TB] FAIL read_window: got %0d..%0d expected 1..%0d", obsRdFirst, obsRdLast, RW); else passCount++;
        checkCount++; if (obsAddrOk != 1'b1) $display("[TB] FAIL read_addr_stable: got %b expected 1", obsAddrOk); else passCount++;
        checkCount++; if (obsRdata !== 32'hDEADBEEF) $display("[TB] FAIL read_data: got %h expected deadbeef", obsRdata); else passCount++;
        checkCount++; if (obsWrHigh != 0) $display("[TB] FAIL read_no_write: got %0d expected 0", obsWrHigh); else passCount++;
    endtask

    task automatic test_write_byte();
        preload(8, 32'h11223344);
        driveTxn(1, 1'b1, 32'h0000_0020, 32'h0000_00A5, 2'b01, -1);
        checkCount++; if (obsWrHigh != 1) $display("[TB] FAIL wbyte_write_cycles: got %0d expected 1", obsWrHigh); else passCount++;
        checkCount++; if (obsWrSrc !== 2'b01) $display("[TB] FAIL wbyte_src: got %b expected 01", obsWrSrc); else passCount++;
        checkCount++; if (obsWrData !== 32'h0000_00A5) $display("[TB] FAIL wbyte_data: got %h expected 000000a5", obsWrData); else passCount++;
        checkCount++; if (obsAckCyc != 2) $display("[TB] FAIL wbyte_ack_cycle: got %0d expected 2", obsAckCyc); else passCount++;
        checkCount++; if (obsAckCnt != 1 || obsOtherAck != 0) $display("[TB] FAIL wbyte_acks: got %0d/%0d expected 1/0", obsAckCnt, obsOtherAck); else passCount++;
        checkCount++; if (devMem[8] !== 32'h112233A5) $display("[TB] FAIL wbyte_memory: got %h expected 112233a5", devMem[8]); else passCount++;
        refMem[8] = 32'h112233A5;
    endtask

    task automatic test_illegal_write();
        preload(16, 32'hCAFEF00D);
        driveTxn(0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 2'b11, -1);
        checkCount++; if (obsWrHigh != 0) $display("[TB] FAIL illegal_write_strobe: got %0d expected 0", obsWrHigh); else passCount++;
        checkCount++; if (devMem[16] !== 32'hCAFEF00D) $display("[TB] FAIL illegal_memory: got %h expected cafef00d", devMem[16]); else passCount++;
        checkCount++; if (obsAckCyc != 2) $display("[TB] FAIL illegal_ack_cycle: got %0d expected 2", obsAckCyc); else passCount++;
        checkCount++; if (obsAckCnt != 1) $display("[TB] FAIL illegal_ack_count: got %0d expected 1", obsAckCnt); else passCount++;
    endtask

    task automatic test_drop_early();
        driveTxn(0, 1'b0, 32'h0000_0010, 32'h0, 2'b00, 2);
        checkCount++; if (obsAckCnt != 1) $display("[TB] FAIL drop_ack_count: got %0d expected 1", obsAckCnt); else passCount++;
        checkCount++; if (obsAckCyc != RW + 1) $display("[TB] FAIL drop_ack_cycle: got %0d expected %0d", obsAckCyc, RW + 1); else passCount++;
        checkCount++; if (obsRdHigh != RW) $display("[TB] FAIL drop_second_grant: got %0d read cycles expected %0d", obsRdHigh, RW); else passCount++;
        checkCount++; if (obsRdata !== refMem[4]) $display("[TB] FAIL drop_data: got %h expected %h", obsRdata, refMem[4]); else passCount++;
    endtask

    task automatic test_random_single();
        for (int k = 0; k < 10; k++) begin
            int port, idx;
            logic we;
            logic [31:0] a, d;
            logic [1:0] src;
            port = $urandom_range(0, 1);
            we   = 1'($urandom_range(0, 1));
            idx  = $urandom_range(0, 15);
            a    = 32'(idx * 4 + $urandom_range(0, 3));
            d    = $urandom;
            src  = 2'($urandom_range(0, 3));
            driveTxn(port, we, a, d, src, -1);
            checkCount++;
            if (obsAckCyc != (we ? 2 : RW + 1) || obsAckCnt != 1 || obsOtherAck != 0)
                $display("[TB] FAIL rand_latency[%0d]: got cyc %0d acks %0d/%0d expected cyc %0d acks 1/0",
                         k, obsAckCyc, obsAckCnt, obsOtherAck, we ? 2 : RW + 1);
            else passCount++;
            if (!we) begin
                checkCount++;
                if (obsRdata !== refMem[idx]) $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", k, obsRdata, refMem[idx]); else passCount++;
            end else begin
                refMem[idx] = applyWrite(refMem[idx], a, d, src);
                checkCount++;
                if (devMem[idx] !== refMem[idx]) $display("[TB] FAIL rand_memory[%0d]: got %h expected %h", k, devMem[idx], refMem[idx]); else passCount++;
                checkCount++;
                if (obsWrHigh != ((src != 2'b11) ? 1 : 0)) $display("[TB] FAIL rand_write_strobe[%0d]: got %0d expected %0d", k, obsWrHigh, (src != 2'b11) ? 1 : 0); else passCount++;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int ackSeen;
        @(negedge clk);
        weV[0] = 1'b0; addrV[0] = 32'h0000_0010; reqV[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checkCount++; if (bus.mem_read !== 1'b1) $display("[TB] FAIL midreset_pre_read: got %b expected 1", bus.mem_read); else passCount++;
        reset = 1'b1;
        #1;
        checkCount++; if (bus.mem_read !== 1'b0) $display("[TB] FAIL midreset_mem_read: got %b expected 0", bus.mem_read); else passCount++;
        checkCount++; if (bus.p0_ack !== 1'b0) $display("[TB] FAIL midreset_ack: got %b expected 0", bus.p0_ack); else passCount++;
        reqV[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ackSeen = 0;
        repeat (RW + 4) begin
            @(negedge clk);
            if (bus.p0_ack === 1'b1 || bus.p1_ack === 1'b1) ackSeen++;
        end
        checkCount++; if (ackSeen != 0) $display("[TB] FAIL midreset_no_ack: got %0d expected 0", ackSeen); else passCount++;
        driveTxn(0, 1'b0, 32'h0000_0014, 32'h0, 2'b00, -1);
        checkCount++; if (obsAckCyc != RW + 1) $display("[TB] FAIL midreset_next_cycle: got %0d expected %0d", obsAckCyc, RW + 1); else passCount++;
        checkCount++; if (obsRdata !== refMem[5]) $display("[TB] FAIL midreset_next_data: got %h expected %h", obsRdata, refMem[5]); else passCount++;
    endtask

    task automatic newOp(input int p, input bit readsOnly);
        opIdx[p]  = $urandom_range(0, 15);
        addrV[p]  = 32'(opIdx[p] * 4 + $urandom_range(0, 3));
        weV[p]    = readsOnly ? 1'b0 : 1'($urandom_range(0, 1));
        wdataV[p] = $urandom;
        wsrcV[p]  = 2'($urandom_range(0, 3));
    endtask

    // Both ports keep a request pending; the model predicts who is served next.
    task automatic test_round_robin(input bit readsOnly, input int nGrants);
        int  lastGrant, got, prevAck, c, p, expP, lat;
        bit  raisePend [2];
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        lastGrant = 1; got = 0; prevAck = -1; c = 0;
        raisePend[0] = 1'b0; raisePend[1] = 1'b0;
        newOp(0, readsOnly); newOp(1, readsOnly);
        reqV = 2'b11;
        while (got < nGrants && c < 40 * nGrants) begin
            @(posedge clk); @(negedge clk); c++;
            for (int q = 0; q < 2; q++) begin
                if (raisePend[q]) begin
                    newOp(q, readsOnly);
                    reqV[q] = 1'b1;
                    raisePend[q] = 1'b0;
                end
            end
            if (bus.p0_ack === 1'b1 || bus.p1_ack === 1'b1) begin
`ifdef ARB_FIXED_PRIO_EN
                expP = 0;
`else
                expP = (lastGrant == 1) ? 0 : 1;
`endif
                lastGrant = expP;
                p   = (bus.p1_ack === 1'b1) ? 1 : 0;
                lat = weV[p] ? 2 : RW + 1;
                checkCount++;
                if (p != expP || (bus.p0_ack === 1'b1 && bus.p1_ack === 1'b1))
                    $display("[TB] FAIL rr_order[%0d]: got port %0d (acks %b%b) expected port %0d", got, p, bus.p1_ack, bus.p0_ack, expP);
                else passCount++;
                checkCount++;
                if (c - prevAck != lat + 1) $display("[TB] FAIL rr_spacing[%0d]: got %0d expected %0d", got, c - prevAck, lat + 1); else passCount++;
                if (!weV[p]) begin
                    checkCount++;
                    if (rdataOf(p) !== refMem[opIdx[p]]) $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", got, rdataOf(p), refMem[opIdx[p]]); else passCount++;
                end else begin
                    refMem[opIdx[p]] = applyWrite(refMem[opIdx[p]], addrV[p], wdataV[p], wsrcV[p]);
                end
                prevAck = c;
                reqV[p] = 1'b0;
                raisePend[p] = 1'b1;
                got++;
            end
        end
        checkCount++; if (got != nGrants) $display("[TB] FAIL rr_timeout: got %0d grants expected %0d", got, nGrants); else passCount++;
        reqV = 2'b00;
        repeat (RW + 4) begin
            @(negedge clk);
            for (int q = 0; q < 2; q++)
                if (ackOf(q) === 1'b1 && weV[q])
                    refMem[opIdx[q]] = applyWrite(refMem[opIdx[q]], addrV[q], wdataV[q], wsrcV[q]);
        end
    endtask

    initial begin
        reset = 1'b1;
        reqV = 2'b00; weV = 2'b00;
        addrV[0] = '0; addrV[1] = '0; wdataV[0] = '0; wdataV[1] = '0;
        wsrcV[0] = 2'b00; wsrcV[1] = 2'b00;
        memInit = 1'b0; preWe = 1'b0; preIdx = '0; preVal = '0;
        initMem();
        test_reset();
        test_read_basic();
        test_write_byte();
        test_illegal_write();
        test_drop_early();
        test_random_single();
        test_reset_mid_read();
        test_round_robin(1'b1, 4);
        test_round_robin(1'b0, 10);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
